// File: rtl/axi_node_pkg.sv
// Shared AXI node types: W order FIFO entry layout and W arbiter FSM states.
package axi_node_pkg;

  localparam int unsigned W_LEN_W          = 8;
  localparam int unsigned NODE_N_TARG_PORT = 8;
  localparam int unsigned NODE_LOG_N       = $clog2(NODE_N_TARG_PORT);

  // Entry layout for the default node size; the arbiter rebuilds the same
  // layout at its own LOG_N so a differently sized node keeps the field order.
  typedef struct packed {
    logic [NODE_LOG_N-1:0] src;
    logic [W_LEN_W-1:0]    len;
  } w_order_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } w_arb_state_e;

endpackage

// File: rtl/axi_w_order_arbiter_if.sv
// Bus bundle for the W order arbiter: AW grant push side plus requester and
// initiator-port W handshakes. Optional macro: AXI_W_LEN_CHECK_EN adds len_error_o.
interface axi_w_order_arbiter_if #(
  parameter  int unsigned N_TARG_PORT = 8,
  localparam int unsigned LOG_N       = $clog2(N_TARG_PORT)
);

  logic                   push_i;
  logic [LOG_N-1:0]       push_src_i;
  logic [7:0]             push_len_i;
  logic                   grant_o;
  logic [N_TARG_PORT-1:0] wvalid_i;
  logic [N_TARG_PORT-1:0] wlast_i;
  logic [N_TARG_PORT-1:0] wready_o;
  logic                   wvalid_o;
  logic                   wlast_o;
  logic                   wready_i;
  logic [LOG_N-1:0]       wsel_o;
  logic                   busy_o;
`ifdef AXI_W_LEN_CHECK_EN
  logic                   len_error_o;

  modport slave (
    input  push_i, push_src_i, push_len_i, wvalid_i, wlast_i, wready_i,
    output grant_o, wready_o, wvalid_o, wlast_o, wsel_o, busy_o, len_error_o
  );
  modport master (
    output push_i, push_src_i, push_len_i, wvalid_i, wlast_i, wready_i,
    input  grant_o, wready_o, wvalid_o, wlast_o, wsel_o, busy_o, len_error_o
  );
`else
  modport slave (
    input  push_i, push_src_i, push_len_i, wvalid_i, wlast_i, wready_i,
    output grant_o, wready_o, wvalid_o, wlast_o, wsel_o, busy_o
  );
  modport master (
    output push_i, push_src_i, push_len_i, wvalid_i, wlast_i, wready_i,
    input  grant_o, wready_o, wvalid_o, wlast_o, wsel_o, busy_o
  );
`endif

endinterface

// File: rtl/axi_order_fifo.sv
// Registered synchronous FIFO (no fall-through) holding outstanding AW grants.
// Push is ignored when full, pop is ignored when empty.
module axi_order_fifo #(
  parameter  int unsigned WIDTH = 3,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_w_order_arbiter.sv
// W data sequencer: forwards requester W beats to the initiator port strictly
// in AW grant order, popping the order FIFO on each accepted WLAST.
// Optional macro: AXI_W_LEN_CHECK_EN (stores AWLEN, flags WLAST/length mismatch).
module axi_w_order_arbiter
  import axi_node_pkg::*;
#(
  parameter  int unsigned N_TARG_PORT = 8,
  parameter  int unsigned FIFO_DEPTH  = 8,
  localparam int unsigned LOG_N       = $clog2(N_TARG_PORT)
) (
  input logic                  clk,
  input logic                  rst_n,
  axi_w_order_arbiter_if.slave bus
);

`ifdef AXI_W_LEN_CHECK_EN
  localparam int unsigned ENTRY_W = LOG_N + W_LEN_W;
`else
  localparam int unsigned ENTRY_W = LOG_N;
`endif
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  w_arb_state_e       state_q, state_d;
  logic [ENTRY_W-1:0] fifo_wdata;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [LOG_N-1:0]   head_src;
  logic [7:0]         beat_cnt;
  logic               in_burst;
  logic               push_ok;
  logic               accept;
  logic               pop;

`ifdef AXI_W_LEN_CHECK_EN
  logic [W_LEN_W-1:0] head_len;
  logic               err_q;
  assign fifo_wdata = {bus.push_src_i, bus.push_len_i};
  assign head_len   = fifo_rdata[W_LEN_W-1:0];
`else
  logic unused_len;
  assign unused_len = ^bus.push_len_i;
  assign fifo_wdata = bus.push_src_i;
`endif

  assign head_src = fifo_rdata[ENTRY_W-1 -: LOG_N];
  assign in_burst = (state_q == BURST);
  assign push_ok  = bus.push_i & ~fifo_full;
  // Accept/pop are derived straight from the selected requester so the
  // output process below never reads its own outputs.
  assign accept   = in_burst & bus.wvalid_i[head_src] & bus.wready_i;
  assign pop      = accept & bus.wlast_i[head_src];

  assign bus.grant_o = ~fifo_full;
  assign bus.busy_o  = ~fifo_empty;

  axi_order_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.push_i),
    .pop   (pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and W steering toward the head requester.
  always_comb begin
    state_d      = state_q;
    bus.wvalid_o = 1'b0;
    bus.wlast_o  = 1'b0;
    bus.wready_o = '0;
    bus.wsel_o   = '0;
    case (state_q)
      IDLE: begin
        if (push_ok) state_d = BURST;
      end
      BURST: begin
        bus.wsel_o             = head_src;
        bus.wvalid_o           = bus.wvalid_i[head_src];
        bus.wlast_o            = bus.wlast_i[head_src];
        bus.wready_o[head_src] = bus.wready_i;
        if (pop && !push_ok && fifo_count == CNT_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Beat counter within the current burst, cleared on the popping WLAST.
  always_ff @(posedge clk) begin
    if (!rst_n)      beat_cnt <= '0;
    else if (pop)    beat_cnt <= '0;
    else if (accept) beat_cnt <= beat_cnt + 1'b1;
  end

`ifdef AXI_W_LEN_CHECK_EN
  // Sticky flag: requester WLAST disagreed with the granted AWLEN.
  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else if (accept && (bus.wlast_i[head_src] != (beat_cnt == head_len))) err_q <= 1'b1;
  end
  assign bus.len_error_o = err_q;
`endif

endmodule

// File: tb/tb_axi_w_order_arbiter.sv
// Self-checking bench for axi_w_order_arbiter: a queue scoreboard of granted
// entries predicts steering, grant/busy and pop order cycle by cycle.
module tb_axi_w_order_arbiter;

  localparam int unsigned N     = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned LOG_N = $clog2(N);

  typedef struct packed {
    logic [LOG_N-1:0] src;
    logic [7:0]       len;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  axi_w_order_arbiter_if #(.N_TARG_PORT(N)) bus ();

  axi_w_order_arbiter #(
    .N_TARG_PORT (N),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] m_beat = '0;
  logic       m_err  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals();
    check("rst_grant",  32'(bus.grant_o),  32'd1);
    check("rst_wvalid", 32'(bus.wvalid_o), 32'd0);
    check("rst_wlast",  32'(bus.wlast_o),  32'd0);
    check("rst_wready", 32'(bus.wready_o), 32'd0);
    check("rst_wsel",   32'(bus.wsel_o),   32'd0);
    check("rst_busy",   32'(bus.busy_o),   32'd0);
    check("rst_beat",   32'(dut.beat_cnt), 32'd0);
  endtask

  task automatic set_w(input logic [N-1:0] v, input logic [N-1:0] l, input logic r);
    bus.wvalid_i = v;
    bus.wlast_i  = l;
    bus.wready_i = r;
  endtask

  // One clock: compare combinational outputs with the scoreboard head, update
  // the model for accepts/pops/pushes, then check registered state after the edge.
  task automatic cycle();
    logic [LOG_N-1:0] hs;
    logic             ev, el, acc, gr;
    logic [N-1:0]     er;
    #1;
    hs = '0; ev = 1'b0; el = 1'b0; er = '0;
    if (sb.size() > 0) begin
      hs     = sb[0].src;
      ev     = bus.wvalid_i[hs];
      el     = bus.wlast_i[hs];
      er[hs] = bus.wready_i;
    end
    gr = (sb.size() != DEPTH);
    check("wvalid_o", 32'(bus.wvalid_o), 32'(ev));
    check("wlast_o",  32'(bus.wlast_o),  32'(el));
    check("wready_o", 32'(bus.wready_o), 32'(er));
    check("wsel_o",   32'(bus.wsel_o),   32'(hs));
    check("grant_o",  32'(bus.grant_o),  32'(gr));
    check("busy_o",   32'(bus.busy_o),   32'(sb.size() != 0));
    acc = ev & bus.wready_i;
    if (acc) begin
      if (el != (m_beat == sb[0].len)) m_err = 1'b1;
      if (el) begin
        check("pop_src", 32'(bus.wsel_o), 32'(sb[0].src));
        void'(sb.pop_front());
        m_beat = '0;
      end else begin
        m_beat = m_beat + 8'd1;
      end
    end
    if (bus.push_i && gr) sb.push_back('{src: bus.push_src_i, len: bus.push_len_i});
    @(posedge clk);
    #2;
    check("beat_cnt", 32'(dut.beat_cnt), 32'(m_beat));
`ifdef AXI_W_LEN_CHECK_EN
    check("len_error_o", 32'(bus.len_error_o), 32'(m_err));
`endif
  endtask

  task automatic push(input logic [LOG_N-1:0] src, input logic [7:0] len);
    bus.push_i     = 1'b1;
    bus.push_src_i = src;
    bus.push_len_i = len;
    cycle();
    bus.push_i     = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.push_i     = 1'b0;
    bus.push_src_i = '0;
    bus.push_len_i = '0;
    set_w('0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    check_reset_vals();
    rst_n = 1'b1;

    // Single-beat burst, then back to idle.
    push(3'd3, 8'd0);
    set_w(8'h08, 8'h08, 1'b1);
    cycle();
    set_w('0, '0, 1'b0);
    cycle();
    check("idle_state", 32'(dut.state_q), 32'd0);

    // Requester 5 waits behind requester 1's 4-beat burst.
    set_w(8'h20, 8'h00, 1'b1);
    push(3'd1, 8'd3);
    push(3'd5, 8'd1);
    set_w(8'h22, 8'h00, 1'b1);
    repeat (3) cycle();
    set_w(8'h22, 8'h02, 1'b1);
    cycle();
    set_w(8'h20, 8'h00, 1'b1);
    cycle();
    set_w(8'h20, 8'h20, 1'b1);
    cycle();
    set_w('0, '0, 1'b0);
    cycle();

    // Fill to full, drop a 9th push, drop a push that coincides with a pop.
    for (int i = 0; i < 8; i++) push(3'(i), 8'd0);
    push(3'd0, 8'd0);
    set_w('1, '1, 1'b1);
    push(3'd7, 8'd0);
    set_w('1, '1, 1'b0);
    cycle();
    set_w('1, '1, 1'b1);
    repeat (7) cycle();
    cycle();

    // Push and pop every cycle so the pointers wrap repeatedly.
    push(3'd0, 8'd0);
    for (int i = 0; i < 20; i++) push(3'((i * 3 + 1) % 8), 8'd0);
    cycle();
    set_w('0, '0, 1'b0);
    cycle();

    // Stall the initiator for 5 cycles mid-burst.
    push(3'd2, 8'd3);
    set_w(8'h04, 8'h00, 1'b1);
    cycle();
    set_w(8'h04, 8'h00, 1'b0);
    repeat (5) cycle();
    set_w(8'h04, 8'h00, 1'b1);
    repeat (2) cycle();
    set_w(8'h04, 8'h04, 1'b1);
    cycle();
    set_w('0, '0, 1'b0);
    cycle();

    // Reset in the middle of a burst.
    push(3'd6, 8'd2);
    set_w(8'h40, 8'h00, 1'b1);
    cycle();
    rst_n = 1'b0;
    set_w('0, '0, 1'b0);
    @(posedge clk);
    #2;
    sb.delete();
    m_beat = '0;
    m_err  = 1'b0;
    check_reset_vals();
    rst_n = 1'b1;
    cycle();

    // Early WLAST against AWLEN=3: entry still pops, error is sticky.
    push(3'd4, 8'd3);
    set_w(8'h10, 8'h00, 1'b1);
    cycle();
    set_w(8'h10, 8'h10, 1'b1);
    cycle();
    set_w('0, '0, 1'b0);
    repeat (2) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_w_order_arbiter.md
Name: axi_w_order_arbiter

Overview:
- Target-side write-data sequencer for the AXI node: shares one initiator-port W channel among N_TARG_PORT target-side requesters.
- The AW arbiter pushes the winning requester index (and burst length) into an internal order FIFO.
- This block forwards W beats strictly in AW-grant order and pops each entry on the accepted WLAST.
- Control only; W payload muxing is done outside, driven by wsel_o.

Parameters:
- N_TARG_PORT, 8, number of requesters (>=2).
- FIFO_DEPTH, 8, outstanding AW grants held (power of 2, >=2).
- LOG_N, $clog2(N_TARG_PORT), index width (derived, do not override).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- push_i  in  1  AW grant event; write src/len into FIFO.
- push_src_i  in  LOG_N  granted requester index.
- push_len_i  in  8  AWLEN of the granted burst (beats-1).
- grant_o  out  1  FIFO not full; push accepted only when high.
- wvalid_i  in  N_TARG_PORT  requester WVALID.
- wlast_i  in  N_TARG_PORT  requester WLAST.
- wready_o  out  N_TARG_PORT  requester WREADY.
- wvalid_o  out  1  WVALID to initiator port.
- wlast_o  out  1  WLAST to initiator port.
- wready_i  in  1  WREADY from initiator port.
- wsel_o  out  LOG_N  payload mux select (head src).
- busy_o  out  1  FIFO non-empty.

Behaviour:
- Reset (sync, rst_n=0 at clk edge): pointers and count=0, state IDLE, beat_cnt=0. After reset: grant_o=1, wvalid_o=0, wlast_o=0, wready_o=0, wsel_o=0, busy_o=0.
- FIFO: registered, no fall-through. An entry pushed in cycle t is visible at head in t+1, so the first W beat can be forwarded at t+1 at the earliest.
- grant_o = (count != FIFO_DEPTH). No push bypass when full: a push with grant_o=0 is dropped and has no state effect.
- A simultaneous push and pop when non-full stores the new entry at the tail and pops the head, so count is unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- FSM IDLE: count==0.
  - All outputs are low except grant_o.
  - Any push moves the FSM to BURST in the next cycle.
- FSM BURST: head = {src,len}, wsel_o=src.
  - wvalid_o = wvalid_i[src]
  - wlast_o = wlast_i[src]
  - wready_o[src] = wready_i; all other wready_o bits = 0.
  - Beats from non-head requesters stall, with no combinational path from them.
- Beat accept: wvalid_o & wready_i. Each accept increments the 8-bit beat_cnt.
- An accept with wlast_o=1 does all of the following:
  - pops the head;
  - clears beat_cnt;
  - stays in BURST if count after pop/push > 0, else goes to IDLE.
- Back-to-back bursts: a new head is served in the cycle after WLAST, with no bubble beyond the register.
- Requester WLAST is authoritative for popping; push_len_i is otherwise unused unless the option below is enabled.
- wvalid_o must not depend on wready_i (AXI rule).
- A reset mid-burst discards all entries; in-flight beats are lost. The upstream must be reset together with this block.

Optional Feature:
- Macro AXI_W_LEN_CHECK_EN.
- When defined:
  - adds output len_error_o (1 bit) and a sticky register err_q, cleared only by reset;
  - err_q sets when an accepted beat has wlast_o != (beat_cnt == head.len);
  - the burst still pops on requester WLAST, so forwarding is unchanged;
  - len_error_o = err_q.
- When undefined:
  - the port is absent;
  - the len field is not stored, so the FIFO width is LOG_N only.

Decomposition:
- Shared package axi_node_pkg holds:
  - typedef w_order_entry_t {src[LOG_N], len[8]};
  - enum w_arb_state_e {IDLE, BURST}.
- One natural sub-module: axi_order_fifo, a parameterised synchronous FIFO with push/pop, full/empty and count.
- FSM, beat counter and steering stay in the top.

Test Plan:
- Push src=3,len=0 at t0; at t1 requester 3 wvalid+wlast and wready_i=1 -> wvalid_o=1, wlast_o=1, wready_o=8'b0000_1000, wsel_o=3; at t2 busy_o=0 and state IDLE.
- Push src=1 len=3 then src=5 len=1 while requester 5 asserts wvalid from t0 -> wready_o[5]=0 until requester 1's 4th beat (wlast) is accepted. Requester 5's first beat is forwarded the cycle after that, then pop.
- Push 8 entries without pops -> grant_o=0 after the 8th. A 9th push is ignored; pop one -> grant_o=1 next cycle; count=7.
- Full FIFO with a same-cycle pop and push -> the push is dropped (grant_o=0), count=7. Non-full same-cycle push+pop -> count unchanged, and order is preserved across pointer wrap (push 20 entries, check src order).
- wready_i=0 for 5 cycles mid-burst -> wvalid_o held, beat_cnt unchanged. Assert rst_n=0 mid-burst -> next cycle all outputs at reset values and grant_o=1.
- AXI_W_LEN_CHECK_EN: push len=3, requester sends wlast on beat 2 -> len_error_o=1 from the next cycle and stays high; the entry still pops.
